sfp_rx_drain: RTL and testbench
===============================

Name: sfp_rx_drain

Overview:
Downstream consumer of the SFP kernel receive path, in the ap_clk domain. It watches the receive-queue flag, issues single-cycle read strobes, and parses each received frame as a header word followed by N payload words. Payload is emitted on a 64-bit valid/ready stream with a last marker. A credit-limited output FIFO absorbs read latency and downstream backpressure.

Parameters:
RD_LAT, 1, cycles from send_start high to the matching sfp_rd_data being valid (1..4)
FIFO_DEPTH, 8, output FIFO entries; power of 2, minimum 4
MAX_LEN, 256, largest legal payload word count per frame

Ports:
ap_clk  input  1  system clock; all logic on rising edge
ap_rst_n  input  1  asynchronous active-low reset
rece_qune  input  1  level; high while at least one received frame is queued
send_start  output  1  one-cycle read strobe; one word per strobe
sfp_rd_data  input  64  read word, valid exactly RD_LAT cycles after its strobe
m_tvalid  output  1  output word valid
m_tdata  output  64  output payload word
m_tlast  output  1  high on the final payload word of a frame
m_tready  input  1  downstream accept; a transfer occurs when m_tvalid and m_tready are both high
busy  output  1  high in any state other than IDLE
frame_cnt  output  32  frames emitted with m_tlast; wraps at 2^32
err_cnt  output  16  malformed headers; saturates at 0xFFFF

Behaviour:
- Reset (async assert, sync release): all outputs 0, FSM in IDLE, FIFO empty, counters 0, in-flight pipeline cleared.
- Read-return tracking: a RD_LAT-deep shift register carries a valid bit, a type bit (header/payload), a last bit and a discard bit for every strobe. The returned word is sampled when the tagged bit exits the shift register.
- Header format: bits [15:0] give the payload length LEN. Bits [63:16] are ignored.
- IDLE: when rece_qune is sampled 1, send_start=1 on the next cycle (registered). FSM then moves to HDR_WAIT.
- HDR_WAIT: no strobes are issued. On header return, latch LEN.
  - LEN=0 or LEN>MAX_LEN: err_cnt+1 and discard=1.
  - LEN=0: FSM returns to IDLE.
  - Otherwise: remaining=LEN and FSM moves to PAYLOAD.
- PAYLOAD: issue one strobe per cycle when remaining>0 and either discard=1 or (fifo_count+inflight)<FIFO_DEPTH, then decrement remaining.
  - The strobe issued with remaining==1 is tagged last.
  - rece_qune is ignored in this state.
  - When remaining==0 and inflight==0, FSM returns to IDLE.
  - Earliest header-to-payload spacing: header strobe at cycle T, first payload strobe at T+RD_LAT+1.
- Return handling: a returned payload word with discard=0 is pushed into the FIFO as {last,data}. With discard=1 it is dropped.
- Overflow: the credit rule guarantees no FIFO overflow. A push into a full FIFO is a design error and must be flagged by an assertion.
- FIFO output: first-word fall-through.
  - m_tvalid rises the cycle after a push into an empty FIFO.
  - m_tdata and m_tlast stay stable while m_tvalid=1 and m_tready=0.
  - A push and a pop in the same cycle are both honoured.
- frame_cnt increments on a transfer with m_tlast=1.
- Back-to-back frames: IDLE re-samples rece_qune on the cycle it is entered. This gives a 1-cycle gap minimum between the last payload return and the next header strobe.
- No combinational path from any input to send_start, m_tvalid, m_tdata or m_tlast.

Test Plan:
- Single frame, RD_LAT=1: header LEN=3 then words A,B,C with m_tready=1 → send_start at T, T+2, T+3, T+4; m_tdata A,B,C on consecutive cycles; m_tlast only on C; frame_cnt=1.
- Backpressure, LEN=20, FIFO_DEPTH=8, m_tready=0 → exactly 8 payload strobes issued, then send_start stays 0. Raising m_tready drains all 20 words in order with no loss or duplication.
- Bad headers: LEN=0 → no strobes after header, err_cnt=1, back to IDLE. LEN=MAX_LEN+1 → MAX_LEN+1 strobes issued, no m_tvalid, err_cnt=2.
- Back-to-back frames with rece_qune held 1, LEN=2 and LEN=1, RD_LAT=3 → 5 strobes total; m_tlast on words 2 and 3; frame_cnt=2.
- Reset mid-frame: assert ap_rst_n=0 during PAYLOAD with 2 words in flight → all outputs 0 immediately. After release, late returns are ignored and the next frame emits correctly.
- Counter limits: preload err_cnt=0xFFFF and frame_cnt=0xFFFFFFFF via force → one more error keeps err_cnt at 0xFFFF; one more frame wraps frame_cnt to 0.

Source files
------------

// File: rtl/sfp_rx_drain.sv
// SFP receive-path drain: strobes words out of the kernel receive queue,
// splits each frame into header + payload, and streams payload words out
// through a credit-limited first-word-fall-through FIFO.
module sfp_rx_drain #(
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned MAX_LEN    = 256
) (
  input  logic        ap_clk,
  input  logic        ap_rst_n,
  input  logic        rece_qune,
  output logic        send_start,
  input  logic [63:0] sfp_rd_data,
  output logic        m_tvalid,
  output logic [63:0] m_tdata,
  output logic        m_tlast,
  input  logic        m_tready,
  output logic        busy,
  output logic [31:0] frame_cnt,
  output logic [15:0] err_cnt
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = $clog2(FIFO_DEPTH + RD_LAT + 1) + 1;
  localparam logic [CW:0]   DEPTH_C   = (CW + 1)'(FIFO_DEPTH);
  localparam logic [15:0]   MAX_LEN_C = 16'(MAX_LEN);
  localparam logic [AW-1:0] PTR_ONE   = {{(AW - 1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_ONE   = {{(CW - 1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE,
    HDR_WAIT,
    PAYLOAD
  } state_t;

  // Per-strobe tag carried alongside the read latency.
  typedef struct packed {
    logic vld;
    logic hdr;
    logic last;
    logic disc;
  } tag_t;

  state_t        state_q, state_d;
  logic [15:0]   remaining_q, remaining_d;
  logic          discard_q, discard_d;
  logic [CW-1:0] inflight_q, inflight_d;
  tag_t          strobe_q, strobe_d;
  tag_t          pipe_q [RD_LAT];
  logic [15:0]   err_cnt_q, err_cnt_d;
  logic [31:0]   frame_cnt_q, frame_cnt_d;

  logic [64:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] fifo_cnt_q, fifo_cnt_d;

  tag_t          ret;
  logic          ret_hdr, ret_pay, push, pop, credit_ok, err_hit;
  logic [15:0]   hdr_len;
  logic          len_zero, len_big;
  logic [64:0]   head;

  assign ret       = pipe_q[RD_LAT-1];
  assign ret_hdr   = ret.vld & ret.hdr;
  assign ret_pay   = ret.vld & ~ret.hdr;
  assign push      = ret_pay & ~ret.disc;
  assign pop       = m_tvalid & m_tready;
  assign hdr_len   = sfp_rd_data[15:0];
  assign len_zero  = (hdr_len == 16'd0);
  assign len_big   = (hdr_len > MAX_LEN_C);
  assign credit_ok = ({1'b0, fifo_cnt_q} + {1'b0, inflight_q}) < DEPTH_C;

  assign head       = mem_q[rd_ptr_q];
  assign m_tvalid   = (fifo_cnt_q != '0);
  assign m_tdata    = m_tvalid ? head[63:0] : '0;
  assign m_tlast    = m_tvalid & head[64];
  assign send_start = strobe_q.vld;
  assign busy       = (state_q != IDLE);
  assign frame_cnt  = frame_cnt_q;
  assign err_cnt    = err_cnt_q;

  // Next-state, strobe issue and header parsing. The first payload strobe is
  // issued on the same edge the header returns so spacing is RD_LAT+1.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    discard_d   = discard_q;
    strobe_d    = '0;
    err_hit     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rece_qune) begin
          strobe_d.vld = 1'b1;
          strobe_d.hdr = 1'b1;
          state_d      = HDR_WAIT;
        end
      end
      HDR_WAIT: begin
        if (ret_hdr) begin
          if (len_zero) begin
            err_hit   = 1'b1;
            discard_d = 1'b1;
            state_d   = IDLE;
          end else begin
            err_hit     = len_big;
            discard_d   = len_big;
            state_d     = PAYLOAD;
            remaining_d = hdr_len;
            if (len_big || credit_ok) begin
              strobe_d.vld  = 1'b1;
              strobe_d.last = (hdr_len == 16'd1);
              strobe_d.disc = len_big;
              remaining_d   = hdr_len - 16'd1;
            end
          end
        end
      end
      PAYLOAD: begin
        if (remaining_q != 16'd0) begin
          if (discard_q || credit_ok) begin
            strobe_d.vld  = 1'b1;
            strobe_d.last = (remaining_q == 16'd1);
            strobe_d.disc = discard_q;
            remaining_d   = remaining_q - 16'd1;
          end
        end else if (inflight_q == {{(CW - 1){1'b0}}, ret_pay}) begin
          // Leave as the final return lands so IDLE can sample next cycle.
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Counter next values: payload in flight, FIFO occupancy, statistics.
  always_comb begin
    inflight_d = inflight_q;
    if ((strobe_d.vld & ~strobe_d.hdr) && !ret_pay) begin
      inflight_d = inflight_q + CNT_ONE;
    end else if (!(strobe_d.vld & ~strobe_d.hdr) && ret_pay) begin
      inflight_d = inflight_q - CNT_ONE;
    end
    fifo_cnt_d = fifo_cnt_q;
    if (push && !pop) begin
      fifo_cnt_d = fifo_cnt_q + CNT_ONE;
    end else if (pop && !push) begin
      fifo_cnt_d = fifo_cnt_q - CNT_ONE;
    end
    err_cnt_d   = (err_hit && (err_cnt_q != '1)) ? err_cnt_q + 16'd1 : err_cnt_q;
    frame_cnt_d = (pop && m_tlast) ? frame_cnt_q + 32'd1 : frame_cnt_q;
  end

  // Control state, strobe tag pipeline and counters.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      discard_q   <= 1'b0;
      inflight_q  <= '0;
      strobe_q    <= '0;
      for (int unsigned i = 0; i < RD_LAT; i++) begin
        pipe_q[i] <= '0;
      end
      err_cnt_q   <= '0;
      frame_cnt_q <= '0;
      fifo_cnt_q  <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      discard_q   <= discard_d;
      inflight_q  <= inflight_d;
      strobe_q    <= strobe_d;
      pipe_q[0]   <= strobe_q;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
      err_cnt_q   <= err_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      fifo_cnt_q  <= fifo_cnt_d;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
    end
  end

  // FIFO storage; contents are qualified by the occupancy count.
  always_ff @(posedge ap_clk) begin
    if (push) mem_q[wr_ptr_q] <= {ret.last, sfp_rd_data};
  end

  fifo_no_overflow_a: assert property (@(posedge ap_clk) disable iff (!ap_rst_n)
    !(push && ({1'b0, fifo_cnt_q} == DEPTH_C)));

endmodule

// File: tb/tb_sfp_rx_drain.sv
// Directed bench for sfp_rx_drain: a kernel-side responder feeds frames,
// a frame-level model predicts the payload stream and counters.
module tb_sfp_rx_drain;

  localparam int unsigned RD_LAT     = 3;
  localparam int unsigned FIFO_DEPTH = 8;
  localparam int unsigned MAX_LEN    = 256;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n = 1'b0;
  logic        rece_qune = 1'b0;
  logic        m_tready = 1'b0;
  logic [63:0] sfp_rd_data = '0;
  logic        send_start, m_tvalid, m_tlast, busy;
  logic [63:0] m_tdata;
  logic [31:0] frame_cnt;
  logic [15:0] err_cnt;

  sfp_rx_drain #(.RD_LAT(RD_LAT), .FIFO_DEPTH(FIFO_DEPTH), .MAX_LEN(MAX_LEN)) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .rece_qune(rece_qune),
    .send_start(send_start), .sfp_rd_data(sfp_rd_data),
    .m_tvalid(m_tvalid), .m_tdata(m_tdata), .m_tlast(m_tlast), .m_tready(m_tready),
    .busy(busy), .frame_cnt(frame_cnt), .err_cnt(err_cnt)
  );

  always #5 ap_clk = ~ap_clk;

  typedef struct { int kind; logic [63:0] data; } wrd_t;   // 0 hdr, 1 kept, 2 dropped
  typedef struct { logic last; logic [63:0] data; } out_t;

  int          total = 0, bad = 0;
  wrd_t        src_q[$];
  out_t        exp_q[$];
  logic [63:0] sched [int];
  int          cyc = 0;
  int          hdr_t[$], pay_t[$], xfer_t[$];
  logic        xlast[$];
  int          kept_strobed = 0, popped = 0;
  logic [31:0] exp_frames = '0;
  logic [15:0] exp_err = '0;
  logic        prev_hold = 1'b0;
  logic [64:0] prev_word = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int at(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1000;
  endfunction

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic clear_logs();
    hdr_t.delete(); pay_t.delete(); xfer_t.delete(); xlast.delete();
  endtask

  task automatic load_frame(input int len);
    wrd_t w; out_t e; logic [63:0] h; bit ok;
    ok = (len >= 1 && len <= int'(MAX_LEN));
    h = {$urandom(), $urandom()};
    h[15:0] = 16'(len);
    w.kind = 0; w.data = h; src_q.push_back(w);
    for (int i = 0; i < len; i++) begin
      w.kind = ok ? 1 : 2;
      w.data = {$urandom(), $urandom()};
      src_q.push_back(w);
      if (ok) begin
        e.last = (i == len - 1); e.data = w.data; exp_q.push_back(e);
      end
    end
    if (!ok && exp_err != 16'hFFFF) exp_err++;
  endtask

  task automatic start_frames(input int nhdr);
    int k = 0;
    rece_qune = 1'b1;
    while (hdr_t.size() < nhdr && k < 2000) begin tick(); k++; end
    rece_qune = 1'b0;
    chk("header_strobe_seen", hdr_t.size() >= nhdr, 1);
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while (!(busy == 1'b0 && m_tvalid == 1'b0 && exp_q.size() == 0 && src_q.size() == 0)
           && k < budget) begin
      tick(); k++;
    end
    chk("idle_reached", k < budget, 1);
    repeat (3) tick();
    chk("err_cnt_model", err_cnt, exp_err);
  endtask

  // Kernel responder plus per-cycle output checks, away from the active edge.
  always @(negedge ap_clk) begin
    wrd_t w; out_t e;
    cyc++;
    if (sched.exists(cyc)) begin
      sfp_rd_data = sched[cyc];
      sched.delete(cyc);
    end else begin
      sfp_rd_data = {$urandom(), $urandom()};
    end
    if (!ap_rst_n) begin
      prev_hold = 1'b0;
    end else begin
      if (send_start) begin
        chk("strobe_has_word", src_q.size() != 0, 1);
        if (src_q.size() != 0) w = src_q.pop_front();
        else begin w.kind = 3; w.data = 64'hBAD0_BAD0_BAD0_BAD0; end
        sched[cyc + RD_LAT] = w.data;
        if (w.kind == 0) hdr_t.push_back(cyc);
        else pay_t.push_back(cyc);
        if (w.kind == 1) kept_strobed++;
      end
      chk("frame_cnt", frame_cnt, exp_frames);
      chk("credit_bound", (kept_strobed - popped) <= int'(FIFO_DEPTH), 1);
      if (prev_hold) begin
        chk("hold_valid", m_tvalid, 1);
        chk("hold_word", {m_tlast, m_tdata}, prev_word);
      end
      if (m_tvalid && m_tready) begin
        chk("xfer_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("tdata", m_tdata, e.data);
          chk("tlast", m_tlast, e.last);
          if (e.last) exp_frames++;
        end
        popped++;
        xfer_t.push_back(cyc);
        xlast.push_back(m_tlast);
      end
      prev_hold = m_tvalid && !m_tready;
      prev_word = {m_tlast, m_tdata};
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int h0;
    // Reset state
    #12;
    chk("rst_send_start", send_start, 0);
    chk("rst_m_tvalid", m_tvalid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_err_cnt", err_cnt, 0);
    tick();
    ap_rst_n = 1'b1;
    m_tready = 1'b1;
    repeat (2) tick();

    // Single frame LEN=3: strobes at T, T+4, T+5, T+6; words at T+8..T+10
    clear_logs();
    load_frame(3);
    start_frames(1);
    wait_idle(200);
    h0 = at(hdr_t, 0);
    chk("t1_pay_strobes", pay_t.size(), 3);
    chk("t1_first_pay_off", at(pay_t, 0) - h0, 4);
    chk("t1_last_pay_off", at(pay_t, 2) - h0, 6);
    chk("t1_first_out_off", at(xfer_t, 0) - h0, 8);
    chk("t1_last_out_off", at(xfer_t, 2) - h0, 10);
    chk("t1_tlast_pattern", {xlast.size() == 3 ? {xlast[0], xlast[1], xlast[2]} : 3'b111}, 3'b001);
    chk("t1_frame_cnt", frame_cnt, 1);

    // Backpressure: LEN=20 with a stalled sink stops at FIFO_DEPTH strobes
    clear_logs();
    m_tready = 1'b0;
    load_frame(20);
    start_frames(1);
    repeat (40) tick();
    chk("t2_pay_strobes_stalled", pay_t.size(), 8);
    chk("t2_valid_stalled", m_tvalid, 1);
    repeat (10) tick();
    chk("t2_pay_strobes_still", pay_t.size(), 8);
    m_tready = 1'b1;
    wait_idle(300);
    chk("t2_pay_strobes_total", pay_t.size(), 20);
    chk("t2_words_out", xfer_t.size(), 20);
    chk("t2_frame_cnt", frame_cnt, 2);

    // Bad headers: LEN=0 then LEN=MAX_LEN+1
    clear_logs();
    load_frame(0);
    start_frames(1);
    wait_idle(100);
    repeat (10) tick();
    chk("t3_len0_pay_strobes", pay_t.size(), 0);
    chk("t3_len0_err", err_cnt, 1);
    chk("t3_len0_idle", busy, 0);
    clear_logs();
    load_frame(MAX_LEN + 1);
    start_frames(1);
    wait_idle(1000);
    chk("t3_big_pay_strobes", pay_t.size(), 257);
    chk("t3_big_no_output", xfer_t.size(), 0);
    chk("t3_big_err", err_cnt, 2);

    // Reset in the middle of a payload burst
    clear_logs();
    load_frame(10);
    start_frames(1);
    begin
      int k = 0;
      while (pay_t.size() < 2 && k < 100) begin tick(); k++; end
      chk("t4_two_in_flight", pay_t.size() >= 2, 1);
    end
    #2 ap_rst_n = 1'b0;
    src_q.delete(); exp_q.delete();
    exp_frames = '0; exp_err = '0; kept_strobed = 0; popped = 0;
    #1;
    chk("t4_rst_send_start", send_start, 0);
    chk("t4_rst_m_tvalid", m_tvalid, 0);
    chk("t4_rst_m_tdata", m_tdata, 0);
    chk("t4_rst_m_tlast", m_tlast, 0);
    chk("t4_rst_busy", busy, 0);
    chk("t4_rst_frame_cnt", frame_cnt, 0);
    chk("t4_rst_err_cnt", err_cnt, 0);
    tick();
    ap_rst_n = 1'b1;
    repeat (3) tick();
    clear_logs();
    load_frame(2);
    start_frames(1);
    wait_idle(200);
    chk("t4_after_words", xfer_t.size(), 2);
    chk("t4_after_frame_cnt", frame_cnt, 1);

    // Back-to-back frames with rece_qune held: LEN=2 then LEN=1
    clear_logs();
    load_frame(2);
    load_frame(1);
    start_frames(2);
    wait_idle(200);
    chk("t5_total_strobes", hdr_t.size() + pay_t.size(), 5);
    chk("t5_tlast_pattern", {xlast.size() == 3 ? {xlast[0], xlast[1], xlast[2]} : 3'b000}, 3'b011);
    chk("t5_gap_min", (at(hdr_t, 1) - at(pay_t, 1)) >= int'(RD_LAT) + 2, 1);
    chk("t5_frame_cnt", frame_cnt, 3);

    // Counter limits
    force dut.err_cnt_q = 16'hFFFF;
    force dut.frame_cnt_q = 32'hFFFF_FFFF;
    exp_err = 16'hFFFF;
    exp_frames = 32'hFFFF_FFFF;
    repeat (2) tick();
    release dut.err_cnt_q;
    release dut.frame_cnt_q;
    tick();
    clear_logs();
    load_frame(0);
    start_frames(1);
    wait_idle(100);
    chk("t6_err_saturated", err_cnt, 16'hFFFF);
    load_frame(1);
    start_frames(2);
    wait_idle(100);
    chk("t6_frame_wrapped", frame_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
